// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and defaults for the fetch/data memory port arbiter
package mem_port_arbiter_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of data grants made while a fetch waits
//   clk_i/rst_n : clock, async active-low reset
//   inc / clr   : count one data grant / clear on fetch grant
//   sat_o       : count has reached LIMIT
module arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat_o
);
  logic [3:0] r_cnt;
  assign sat_o = r_cnt == 4'(LIMIT);
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc && !sat_o) r_cnt <= r_cnt + 4'd1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between a fetch port and a data port
//   i_*  : fetch port (read-only), level request held until i_ack_o
//   d_*  : data port (read/write), level request held until d_ack_o
//   m_*  : memory side, request held stable until m_ready_i
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic              m_ready_i
);
  state_t r_state;
  logic   w_sat;
  logic   w_any;
  gnt_t   w_gnt;
  // data wins ties unless the fetch has already been passed over STARVE_LIMIT times
  assign w_any = r_state == IDLE && (i_req_i || d_req_i);
  assign w_gnt = (d_req_i && !(i_req_i && w_sat)) ? GNT_D : GNT_I;
  arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .inc  (w_any && w_gnt == GNT_D && i_req_i),
    .clr  (w_any && w_gnt == GNT_I),
    .sat_o(w_sat)
  );
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      i_rdata_o <= '0;
      i_ack_o   <= 1'b0;
      d_rdata_o <= '0;
      d_ack_o   <= 1'b0;
      m_req_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (w_any) begin
            r_state   <= w_gnt == GNT_D ? BUSY_D : BUSY_I;
            m_req_o   <= 1'b1;
            m_we_o    <= w_gnt == GNT_D && d_we_i;
            m_addr_o  <= w_gnt == GNT_D ? d_addr_i : i_addr_i;
            m_wdata_o <= w_gnt == GNT_D ? d_wdata_i : '0;
          end
        BUSY_I, BUSY_D:
          if (m_ready_i) begin
            r_state <= RESP;
            m_req_o <= 1'b0;
            m_we_o  <= 1'b0;
            if (r_state == BUSY_I) begin
              i_ack_o   <= 1'b1;
              i_rdata_o <= m_rdata_i;
            end else begin
              d_ack_o <= 1'b1;
              if (!m_we_o) d_rdata_o <= m_rdata_i;
            end
          end
        // one dead cycle so a request still high during its ack is not granted again
        RESP: begin
          r_state <= IDLE;
          i_ack_o <= 1'b0;
          d_ack_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic [31:0] i_rdata_o;
  logic        i_ack_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i = '0;
  logic        m_ready_i = 1'b0;
  always #5 clk_i = ~clk_i;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_ack_o(i_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_rdata_i(m_rdata_i), .m_ready_i(m_ready_i)
  );
  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          drop_at;
    int          exp_lat;
  } vec_t;
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem_rdata = '0;
  int          mem_delay = 0;
  int          busy_cnt = 0;
  logic [31:0] mdl_i_rdata = '0;
  logic [31:0] mdl_d_rdata = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // memory model: m_ready_i after mem_delay wait cycles; noise on m_ready_i when idle
  initial forever begin
    @(negedge clk_i);
    if (m_req_o) begin
      if (sb.size() == 0) chk("m_req_unexpected", 32'(m_req_o), 0);
      else begin
        chk("m_addr", m_addr_o, sb[0].addr);
        chk("m_we", 32'(m_we_o), 32'(sb[0].we));
        if (sb[0].we) chk("m_wdata", m_wdata_o, sb[0].wdata);
      end
      m_ready_i = busy_cnt == mem_delay;
      m_rdata_i = m_ready_i ? mem_rdata : $urandom;
      busy_cnt++;
    end else begin
      busy_cnt  = 0;
      m_ready_i = 1'($urandom_range(0, 1));
      m_rdata_i = $urandom;
    end
  end
  // ack monitor: pops the scoreboard and checks both read-data outputs
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (rst_n && (i_ack_o || d_ack_o)) begin
      chk("one_ack", 32'(i_ack_o & d_ack_o), 0);
      if (sb.size() == 0) chk("ack_unexpected", 32'(i_ack_o | d_ack_o), 0);
      else begin
        e = sb.pop_front();
        chk("ack_port", 32'(d_ack_o), 32'(e.is_d));
        if (e.is_d && !e.we) mdl_d_rdata = e.rdata;
        if (!e.is_d) mdl_i_rdata = e.rdata;
        chk("d_rdata", d_rdata_o, mdl_d_rdata);
        chk("i_rdata", i_rdata_o, mdl_i_rdata);
      end
    end
  end
  task automatic wait_ack(input int drop_at, output int n, output logic got_d);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (n == drop_at) begin
        i_req_i = 1'b0;
        d_req_i = 1'b0;
      end
    end while (!(i_ack_o || d_ack_o) && n < 60);
    if (!(i_ack_o || d_ack_o)) chk("ack_timeout", 32'(n), 0);
    got_d = d_ack_o;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t vt[6];
    int   n;
    logic gd;
    vt[0] = '{is_d:1'b0, we:1'b0, addr:32'h40,  wdata:32'h0,        rdata:32'h8C020004, delay:0, drop_at:0, exp_lat:3};
    vt[1] = '{is_d:1'b1, we:1'b0, addr:32'h100, wdata:32'h0,        rdata:32'h11223344, delay:1, drop_at:0, exp_lat:4};
    vt[2] = '{is_d:1'b1, we:1'b1, addr:32'h10,  wdata:32'hDEADBEEF, rdata:32'h77777777, delay:0, drop_at:0, exp_lat:3};
    vt[3] = '{is_d:1'b1, we:1'b1, addr:32'h20,  wdata:32'hCAFEF00D, rdata:32'h66666666, delay:7, drop_at:0, exp_lat:10};
    vt[4] = '{is_d:1'b0, we:1'b0, addr:32'h44,  wdata:32'h0,        rdata:32'h12345678, delay:2, drop_at:2, exp_lat:5};
    vt[5] = '{is_d:1'b1, we:1'b0, addr:32'h30,  wdata:32'h0,        rdata:32'hA5A5A5A5, delay:0, drop_at:2, exp_lat:3};
    #1 rst_n = 1'b0;
    #2;
    chk("rst_m_req", 32'(m_req_o), 0);
    chk("rst_m_we", 32'(m_we_o), 0);
    chk("rst_m_addr", m_addr_o, 0);
    chk("rst_m_wdata", m_wdata_o, 0);
    chk("rst_i_ack", 32'(i_ack_o), 0);
    chk("rst_d_ack", 32'(d_ack_o), 0);
    chk("rst_i_rdata", i_rdata_o, 0);
    chk("rst_d_rdata", d_rdata_o, 0);
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_rdata = vt[i].rdata;
      mem_delay = vt[i].delay;
      sb.push_back('{is_d:vt[i].is_d, we:vt[i].we, addr:vt[i].addr, wdata:vt[i].wdata, rdata:vt[i].rdata});
      @(posedge clk_i);
      #1;
      if (vt[i].is_d) begin
        d_req_i = 1'b1;
        d_we_i = vt[i].we;
        d_addr_i = vt[i].addr;
        d_wdata_i = vt[i].wdata;
      end else begin
        i_req_i = 1'b1;
        i_addr_i = vt[i].addr;
      end
      wait_ack(vt[i].drop_at, n, gd);
      i_req_i = 1'b0;
      d_req_i = 1'b0;
      chk($sformatf("vec%0d_latency", i), 32'(n), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_port", i), 32'(gd), 32'(vt[i].is_d));
    end
    // simultaneous write and fetch: data served first
    mem_rdata = 32'h0BADF00D;
    mem_delay = 0;
    sb.push_back('{is_d:1'b1, we:1'b1, addr:32'h10, wdata:32'hDEADBEEF, rdata:32'h0});
    sb.push_back('{is_d:1'b0, we:1'b0, addr:32'h48, wdata:32'h0, rdata:32'h0BADF00D});
    @(posedge clk_i);
    #1;
    i_req_i = 1'b1;
    i_addr_i = 32'h48;
    d_req_i = 1'b1;
    d_we_i = 1'b1;
    d_addr_i = 32'h10;
    d_wdata_i = 32'hDEADBEEF;
    wait_ack(0, n, gd);
    d_req_i = 1'b0;
    chk("both_first_is_d", 32'(gd), 1);
    chk("both_first_lat", 32'(n), 3);
    wait_ack(0, n, gd);
    i_req_i = 1'b0;
    chk("both_second_is_i", 32'(gd), 0);
    chk("both_second_lat", 32'(n), 3);
    // starvation: both held, expect four data grants then a fetch, twice
    mem_rdata = 32'h55AA0001;
    for (int k = 0; k < 10; k++)
      sb.push_back('{is_d:(k % 5 != 4), we:1'b0, addr:(k % 5 != 4) ? 32'h200 : 32'h300, wdata:32'h0, rdata:32'h55AA0001});
    @(posedge clk_i);
    #1;
    i_req_i = 1'b1;
    i_addr_i = 32'h300;
    d_req_i = 1'b1;
    d_we_i = 1'b0;
    d_addr_i = 32'h200;
    for (int k = 0; k < 10; k++) begin
      wait_ack(0, n, gd);
      chk($sformatf("starve_order%0d", k), 32'(gd), 32'(k % 5 != 4));
    end
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    // reset during BUSY_I: transaction discarded, fetch re-served afterwards
    mem_rdata = 32'h13579BDF;
    mem_delay = 5;
    sb.push_back('{is_d:1'b0, we:1'b0, addr:32'h80, wdata:32'h0, rdata:32'h13579BDF});
    @(posedge clk_i);
    #1;
    i_req_i = 1'b1;
    i_addr_i = 32'h80;
    repeat (3) @(negedge clk_i);
    chk("pre_rst_m_req", 32'(m_req_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_m_req", 32'(m_req_o), 0);
    chk("rst_mid_i_rdata", i_rdata_o, 0);
    chk("rst_mid_d_rdata", d_rdata_o, 0);
    sb.delete();
    mdl_i_rdata = '0;
    mdl_d_rdata = '0;
    repeat (2) begin
      @(negedge clk_i);
      chk("rst_no_i_ack", 32'(i_ack_o), 0);
      chk("rst_hold_m_req", 32'(m_req_o), 0);
    end
    sb.push_back('{is_d:1'b0, we:1'b0, addr:32'h80, wdata:32'h0, rdata:32'h13579BDF});
    rst_n = 1'b1;
    wait_ack(0, n, gd);
    i_req_i = 1'b0;
    chk("rst_reserve_port", 32'(gd), 0);
    chk("rst_reserve_lat", 32'(n), 7);
    // fetch held through its ack: no grant in RESP, a fresh grant from IDLE
    mem_rdata = 32'h2468ACE0;
    mem_delay = 0;
    sb.push_back('{is_d:1'b0, we:1'b0, addr:32'h90, wdata:32'h0, rdata:32'h2468ACE0});
    sb.push_back('{is_d:1'b0, we:1'b0, addr:32'h90, wdata:32'h0, rdata:32'h2468ACE0});
    @(posedge clk_i);
    #1;
    i_req_i = 1'b1;
    i_addr_i = 32'h90;
    wait_ack(0, n, gd);
    chk("hold_first_lat", 32'(n), 3);
    @(negedge clk_i);
    chk("hold_idle_no_m_req", 32'(m_req_o), 0);
    @(negedge clk_i);
    chk("hold_regrant_m_req", 32'(m_req_o), 1);
    wait_ack(0, n, gd);
    i_req_i = 1'b0;
    chk("hold_second_lat", 32'(n), 1);
    repeat (3) @(negedge clk_i);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
